// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for a 5-stage MIPS-style pipeline.
//
// An E-stage MULT/MULTU/DIV/DIVU computes its 64-bit result when the operation
// is accepted and holds it in pending registers. The unit then stays busy for
// a fixed number of cycles, mimicking a multi-cycle unit. After that it commits
// the pending value to HI/LO and pulses done. MTHI/MTLO write HI/LO directly
// when the unit is idle.
//
// Parameters:
//   MULT_CYC  busy cycles for MULT/MULTU (1..15)
//   DIV_CYC   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk       clock; all state updates on its rising edge
//   reset     asynchronous, active-low reset
//   start     E-stage MDU instruction valid this cycle
//   op        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   rs_val    forwarded rs operand
//   rt_val    forwarded rt operand
//   d_is_md   D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
//   busy      operation in progress
//   stall_md  hold PC and F/D, flush D/E
//   done      one-cycle pulse when HI/LO take an operation result
//   hi, lo    architectural HI/LO registers
module mdu_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  localparam logic [3:0] MultCnt = 4'(MULT_CYC);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYC);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;   // clear for divide-by-zero: HI/LO stay untouched

  // ---------------------------------------------------------------------------
  // Result datapath, evaluated on the operands present at the accepting edge.
  // ---------------------------------------------------------------------------
  logic               is_arith;
  logic               is_div;
  logic               div_by_zero;
  logic signed [63:0] mul_a_s;
  logic signed [63:0] mul_b_s;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               rs_neg;
  logic               rt_neg;
  logic        [31:0] rs_mag;
  logic        [31:0] rt_mag;
  logic        [31:0] divisor;
  logic        [31:0] quo_mag;
  logic        [31:0] rem_mag;
  logic        [31:0] quo;
  logic        [31:0] rem;
  logic        [31:0] res_hi;
  logic        [31:0] res_lo;

  assign is_arith    = ~op[2];
  assign is_div      = is_arith & op[1];
  assign div_by_zero = (rt_val == 32'd0);

  always_comb begin
    mul_a_s = {{32{rs_val[31]}}, rs_val};
    mul_b_s = {{32{rt_val[31]}}, rt_val};
    prod_s  = mul_a_s * mul_b_s;
    prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
  end

  // Signed division goes through magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0 instead of relying on overflow behaviour of
  // the signed operator. Magnitude of 0x80000000 is 0x80000000 as unsigned.
  always_comb begin
    rs_neg  = (op == OpDiv) & rs_val[31];
    rt_neg  = (op == OpDiv) & rt_val[31];
    rs_mag  = rs_neg ? (32'd0 - rs_val) : rs_val;
    rt_mag  = rt_neg ? (32'd0 - rt_val) : rt_val;
    // A zero divisor never commits; substitute 1 to keep the divider defined.
    divisor = div_by_zero ? 32'd1 : rt_mag;
    quo_mag = rs_mag / divisor;
    rem_mag = rs_mag % divisor;
    quo     = (rs_neg ^ rt_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem     = rs_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OpMult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OpMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OpDiv, OpDivu: begin
        res_hi = rem;
        res_lo = quo;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= StIdle;
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            if (is_arith) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_wr <= ~(is_div & div_by_zero);
              cnt     <= is_div ? DivCnt : MultCnt;
              state   <= StRun;
            end else if (op == OpMthi) begin
              hi <= rs_val;
            end else if (op == OpMtlo) begin
              lo <= rs_val;
            end
          end
        end
        StRun: begin
          // New starts are ignored here; the pipeline is stalled anyway.
          if (cnt == 4'd1) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            done  <= 1'b1;
            cnt   <= 4'd0;
            state <= StIdle;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy     = (state == StRun);
  assign stall_md = d_is_md & (busy | (start & is_arith));

endmodule
